// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned ARB_MODE_FIXED = 0;
  localparam int unsigned ARB_MODE_RR    = 1;
  localparam int unsigned MAX_MASTERS    = 8;
  localparam int unsigned MAX_RD_LAT     = 4;
  localparam int unsigned ID_W           = $clog2(MAX_MASTERS);

  // Read-response tag carried down the latency pipeline
  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } rd_tag_t;

  function automatic logic [MAX_MASTERS-1:0] id_onehot(input logic [ID_W-1:0] id);
    return MAX_MASTERS'(1) << id;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority picker: the request at i_ptr has top priority, then i_ptr+1, ... mod N.
module rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_gnt_idx,
  output logic          o_gnt_valid
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;

  // Doubling the vector lets a plain shift implement the modular rotation
  assign w_dbl = {i_req, i_req};
  assign w_rot = N'(w_dbl >> i_ptr);

  always_comb begin
    o_gnt_idx   = '0;
    o_gnt_valid = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!o_gnt_valid && w_rot[k]) begin
        o_gnt_valid = 1'b1;
        o_gnt_idx   = PW'((32'(i_ptr) + k) % N);
      end
    end
    o_gnt = o_gnt_valid ? (N'(1) << o_gnt_idx) : '0;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-master to 1-slave data-memory port arbiter with in-order read-response routing.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned ARB_MODE  = ARB_MODE_FIXED
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_MASTERS-1:0]      m_req_i,
  input  logic [N_MASTERS-1:0]      m_we_i,
  input  logic [N_MASTERS*AW-1:0]   m_addr_bi,
  input  logic [N_MASTERS*DW-1:0]   m_wdata_bi,
  input  logic [N_MASTERS*DW/8-1:0] m_be_bi,
  output logic [N_MASTERS-1:0]      m_ack_o,
  output logic [N_MASTERS-1:0]      m_resp_o,
  output logic [DW-1:0]             m_rdata_bo,
  output logic                      s_req_o,
  output logic                      s_we_o,
  output logic [AW-1:0]             s_addr_bo,
  output logic [DW-1:0]             s_wdata_bo,
  output logic [DW/8-1:0]           s_be_bo,
  input  logic [DW-1:0]             s_rdata_bi
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned IW = $clog2(N_MASTERS);

  if (N_MASTERS < 2 || N_MASTERS > MAX_MASTERS || RD_LAT < 1 || RD_LAT > MAX_RD_LAT ||
      (DW % 8) != 0) begin : g_param_err
    $error("mem_port_arbiter: illegal parameter set");
  end

  logic                 r_rst_q;
  logic [IW-1:0]        r_rr_ptr;
  rd_tag_t              r_tag [RD_LAT];

  logic [IW-1:0]        w_arb_ptr;
  logic [N_MASTERS-1:0] w_arb_gnt;
  logic [IW-1:0]        w_arb_idx;
  logic                 w_arb_valid;
  logic                 w_en;
  logic                 w_gnt_valid;
  logic [N_MASTERS-1:0] w_gnt;
  rd_tag_t              w_new_tag;
  rd_tag_t              w_tail;

  // Fixed mode is the same picker with the top-priority slot pinned to master 0
  assign w_arb_ptr = (ARB_MODE == ARB_MODE_RR) ? r_rr_ptr : '0;

  rr_arbiter #(
    .N  (N_MASTERS),
    .PW (IW)
  ) u_rr_arbiter (
    .i_req       (m_req_i),
    .i_ptr       (w_arb_ptr),
    .o_gnt       (w_arb_gnt),
    .o_gnt_idx   (w_arb_idx),
    .o_gnt_valid (w_arb_valid)
  );

  // Issue is blocked during reset and the cycle right after it
  assign w_en        = !rst_i && !r_rst_q;
  assign w_gnt_valid = w_en && w_arb_valid;
  assign w_gnt       = w_en ? w_arb_gnt : '0;
  assign m_ack_o     = w_gnt;
  assign s_req_o     = w_gnt_valid;

  always_comb begin
    s_we_o     = 1'b0;
    s_addr_bo  = '0;
    s_wdata_bo = '0;
    s_be_bo    = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (w_gnt[i]) begin
        s_we_o     = m_we_i[i];
        s_addr_bo  = m_addr_bi[i*AW +: AW];
        s_wdata_bo = m_wdata_bi[i*DW +: DW];
        s_be_bo    = m_be_bi[i*BW +: BW];
      end
    end
  end

  assign w_new_tag.valid = w_gnt_valid && !s_we_o;
  assign w_new_tag.id    = ID_W'(w_arb_idx);
  assign w_tail          = r_tag[RD_LAT-1];

  assign m_resp_o   = (w_tail.valid && !rst_i) ? N_MASTERS'(id_onehot(w_tail.id)) : '0;
  assign m_rdata_bo = s_rdata_bi;

  always_ff @(posedge clk_i) begin
    r_rst_q <= rst_i;
    if (rst_i) begin
      r_rr_ptr <= '0;
    end else if (w_gnt_valid && ARB_MODE == ARB_MODE_RR) begin
      r_rr_ptr <= (32'(w_arb_idx) == N_MASTERS - 1) ? '0 : w_arb_idx + IW'(1);
    end
  end

  // Read tags travel RD_LAT stages so the tail lines up with slave data
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < RD_LAT; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= w_new_tag;
      for (int unsigned i = 1; i < RD_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

endmodule
